// File: rtl/matvec_mac_sched.sv
// Serialised unsigned matrix-vector multiply: one MAC, one row at a time,
// each row result handed out over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; captures M and X on start
// RUN   | accumulating one element product per cycle
// OUT   | holding a row result until y_valid && y_ready
// DONE  | one-cycle done pulse, then back to IDLE
module matvec_mac_sched #(
  parameter int Nbits = 4,
  parameter int Ndata = 4,
  parameter int Nrows = 2,
  localparam int ACCW = 2*Nbits + $clog2(Ndata),
  localparam int IW   = (Nrows > 1) ? $clog2(Nrows) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [Nrows*Ndata*Nbits-1:0] M,
  input  logic [Ndata*Nbits-1:0]       X,
  output logic                         busy,
  output logic                         y_valid,
  input  logic                         y_ready,
  output logic [ACCW-1:0]              y_data,
  output logic [IW-1:0]                y_index,
  output logic                         done
);

  localparam int CW = $clog2(Ndata);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CW-1:0] COL_LAST = CW'(Ndata - 1);
  localparam logic [IW-1:0] ROW_LAST = IW'(Nrows - 1);

  logic [1:0]       state;
  logic [IW-1:0]    row;
  logic [CW-1:0]    col;
  logic [ACCW-1:0]  acc;
  logic [Nbits-1:0] m_cap [Nrows][Ndata];
  logic [Nbits-1:0] x_cap [Ndata];

  logic [Nbits-1:0]   m_el;
  logic [Nbits-1:0]   x_el;
  logic [2*Nbits-1:0] prod;
  logic [ACCW-1:0]    acc_next;

  // ACCW leaves log2(Ndata) headroom bits above the product, so the sum is exact
  assign m_el     = m_cap[row][col];
  assign x_el     = x_cap[col];
  assign prod     = {{Nbits{1'b0}}, m_el} * {{Nbits{1'b0}}, x_el};
  assign acc_next = acc + {{(ACCW-2*Nbits){1'b0}}, prod};

  assign busy = (state == S_RUN) || (state == S_OUT);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      row     <= '0;
      col     <= '0;
      acc     <= '0;
      y_valid <= 1'b0;
      y_data  <= '0;
      y_index <= '0;
      for (int r = 0; r < Nrows; r++)
        for (int k = 0; k < Ndata; k++)
          m_cap[r][k] <= '0;
      for (int k = 0; k < Ndata; k++)
        x_cap[k] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int r = 0; r < Nrows; r++)
              for (int k = 0; k < Ndata; k++)
                m_cap[r][k] <= M[(r*Ndata + k)*Nbits +: Nbits];
            for (int k = 0; k < Ndata; k++)
              x_cap[k] <= X[k*Nbits +: Nbits];
            row   <= '0;
            col   <= '0;
            acc   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc_next;
          col <= col + CW'(1);
          if (col == COL_LAST) begin
            y_data  <= acc_next;
            y_index <= row;
            y_valid <= 1'b1;
            state   <= S_OUT;
          end
        end
        S_OUT: begin
          if (y_valid && y_ready) begin
            y_valid <= 1'b0;
            if (row == ROW_LAST) begin
              state <= S_DONE;
            end else begin
              row   <= row + IW'(1);
              col   <= '0;
              acc   <= '0;
              state <= S_RUN;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_mac_sched.sv
// Scoreboard bench for matvec_mac_sched: row results predicted at start,
// compared in order as each row handshake happens, plus timing checks.
module tb_matvec_mac_sched;
  localparam int NB   = 4;
  localparam int ND   = 4;
  localparam int NR   = 2;
  localparam int ACCW = 2*NB + $clog2(ND);

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [NR*ND*NB-1:0]   M;
  logic [ND*NB-1:0]      X;
  logic                  busy;
  logic                  y_valid;
  logic                  y_ready;
  logic [ACCW-1:0]       y_data;
  logic [0:0]            y_index;
  logic                  done;

  matvec_mac_sched #(.Nbits(NB), .Ndata(ND), .Nrows(NR)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .M       (M),
    .X       (X),
    .busy    (busy),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_data  (y_data),
    .y_index (y_index),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {int idx; int data;} exp_t;
  exp_t sb[$];

  localparam logic [NR*ND*NB-1:0] M_BASIC = {16'h1FFF, 16'h2321};
  localparam logic [ND*NB-1:0]    X_BASIC = 16'h1456;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job();
    for (int r = 0; r < NR; r++) begin
      int s;
      s = 0;
      for (int k = 0; k < ND; k++)
        s += int'(M[(r*ND + k)*NB +: NB]) * int'(X[k*NB +: NB]);
      sb.push_back('{r, s});
    end
  endtask

  // Edge numbering: the edge that samples start is edge 1.
  task automatic run_job(input int stall, input bit disturb);
    int edge_n;
    int busy_n;
    int row;
    int stall_left;
    bit done_seen;
    bit first_of_row;
    push_job();
    y_ready = 1'b1;
    start   = 1'b1;
    step();
    edge_n = 1;
    start  = 1'b0;
    if (disturb) begin
      start = 1'b1;
      M     = '0;
      X     = '0;
    end
    row = 0; busy_n = 0; done_seen = 0; first_of_row = 1; stall_left = stall;
    while (!done_seen && edge_n < 200) begin
      if (disturb && edge_n == 3) start = 1'b0;
      if (busy) busy_n++;
      if (y_valid) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          chk("y_data", int'(y_data), sb[0].data);
          chk("y_index", int'(y_index), sb[0].idx);
          if (first_of_row) begin
            chk("valid_edge", edge_n, (ND+1)*(row+1) + ((row > 0) ? stall : 0));
            first_of_row = 0;
          end
          if (row == 0 && stall_left > 0) begin
            y_ready = 1'b0;
            stall_left--;
          end else begin
            y_ready = 1'b1;
            void'(sb.pop_front());
            row++;
            first_of_row = 1;
          end
        end
      end
      if (done) begin
        done_seen = 1;
        chk("done_edge", edge_n, (ND+1)*NR + 1 + stall);
        chk("busy_cycles", busy_n, (ND+1)*NR + stall);
        chk("rows_out", row, NR);
      end
      if (!done_seen) begin
        step();
        edge_n++;
      end
    end
    if (!done_seen) chk("timeout", 0, 1);
    y_ready = 1'b1;
    step();
    chk("done_pulse", int'(done), 0);
    chk("busy_idle", int'(busy), 0);
  endtask

  initial begin
    int done_cnt;
    int busy_cnt;
    reset = 1'b1; start = 1'b0; y_ready = 1'b1;
    M = M_BASIC; X = X_BASIC;
    step(); step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(y_valid), 0);
    chk("rst_data", int'(y_data), 0);
    chk("rst_index", int'(y_index), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    step();

    // basic rows, then back-to-back with start the cycle after done
    run_job(0, 0);
    run_job(0, 0);

    // all-max elements: 4*15*15 = 900 per row
    M = '1; X = '1;
    run_job(0, 0);
    M = M_BASIC; X = X_BASIC;
    step();

    // backpressure on row 0
    run_job(7, 0);
    step();

    // start re-pulsed during RUN, inputs zeroed after capture
    run_job(0, 1);
    busy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (busy) busy_cnt++;
    end
    chk("no_second_job", busy_cnt, 0);
    M = M_BASIC; X = X_BASIC;

    // reset during row 1 RUN
    y_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    chk("pre_rst_busy", int'(busy), 1);
    reset = 1'b1;
    step();
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_valid", int'(y_valid), 0);
    chk("mid_rst_data", int'(y_data), 0);
    chk("mid_rst_index", int'(y_index), 0);
    chk("mid_rst_done", int'(done), 0);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done || busy) done_cnt++;
    end
    chk("post_rst_quiet", done_cnt, 0);
    run_job(0, 0);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
